// File: rtl/riscv_mem_pkg.sv
// Constants and FSM state type shared by the main-memory responder and memory_system.
// The cache line size is derived from the same defaults so both sides agree on burst length.
package riscv_mem_pkg;

    localparam int WORD_W              = 32;
    localparam int DEFAULT_BLOCK_WORDS = 4;
    localparam int DEFAULT_LATENCY     = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_BURST,
        WR_BURST,
        DONE
    } mem_state_t;

endpackage

// File: rtl/main_memory_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, zero latency.
// No backpressure; contents survive reset.
module main_memory_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory burst responder: LATENCY wait cycles after accept, then one block of BLOCK_WORDS beats.
// Requests are only sampled in IDLE; bursts run without backpressure.
module main_memory_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 256,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic              mem_wdata_ack,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_rvalid,
    output logic              mem_done,
    output logic              mem_busy
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int BEAT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0]  BLK_MASK  = ~IDX_W'(BLOCK_WORDS - 1);

    mem_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [BEAT_W-1:0] beat;
    logic [IDX_W-1:0]  base;
    logic              we_lat;
    logic              last_beat;
    logic [IDX_W-1:0]  req_idx, rd_idx, wr_idx;
    logic [WORD_W-1:0] arr_rdata;
    logic              arr_we;
    logic [ADDR_W-1:0] addr_unused;

    // Byte offset and bits above the storage range are don't-care.
    assign addr_unused = mem_addr;
    assign req_idx     = mem_addr[IDX_W+1:2] & BLK_MASK;
    assign last_beat   = (beat == LAST_BEAT);

    // Read port looks one beat ahead so mem_rdata can be registered alongside mem_rvalid.
    assign rd_idx = (state == RD_BURST) ? base + IDX_W'(beat) + IDX_W'(1) : base;
    assign wr_idx = base + IDX_W'(beat);
    assign arr_we = (state == WR_BURST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (mem_req) state_nxt = WAIT;
            WAIT:     if (cnt == '0) state_nxt = we_lat ? WR_BURST : RD_BURST;
            RD_BURST: if (last_beat) state_nxt = DONE;
            WR_BURST: if (last_beat) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_busy      = (state != IDLE);
        mem_done      = (state == DONE);
        mem_wdata_ack = (state == WR_BURST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            beat       <= '0;
            base       <= '0;
            we_lat     <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            if (state == IDLE && mem_req) begin
                base   <= req_idx;
                we_lat <= mem_we;
                cnt    <= CNT_LOAD;
            end
            if (state == WAIT) begin
                beat <= '0;
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end else if (state == RD_BURST || state == WR_BURST) begin
                beat <= last_beat ? '0 : beat + BEAT_W'(1);
            end
            mem_rvalid <= (state_nxt == RD_BURST);
            mem_rdata  <= (state_nxt == RD_BURST) ? arr_rdata : '0;
        end
    end

    main_memory_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .waddr(wr_idx),
        .wdata(mem_wdata),
        .raddr(rd_idx),
        .rdata(arr_rdata)
    );

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench: dut_a (ADDR_W=12, LATENCY=4, 4-word blocks) and dut_b (LATENCY=1, 8-word blocks).
module tb_main_memory_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    int          sel = 0;

    logic        req_a, ack_a, rvalid_a, done_a, busy_a;
    logic        req_b, ack_b, rvalid_b, done_b, busy_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ack, rvalid, done, busy;
    logic [31:0] rdata;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [2][256];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    assign req_a  = req && (sel == 0);
    assign req_b  = req && (sel == 1);
    assign ack    = (sel == 0) ? ack_a    : ack_b;
    assign rvalid = (sel == 0) ? rvalid_a : rvalid_b;
    assign done   = (sel == 0) ? done_a   : done_b;
    assign busy   = (sel == 0) ? busy_a   : busy_b;
    assign rdata  = (sel == 0) ? rdata_a  : rdata_b;

    main_memory_ctrl #(.ADDR_W(12), .DEPTH(256), .BLOCK_WORDS(4), .LATENCY(4)) dut_a (
        .clk(clk), .reset(reset), .mem_req(req_a), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wdata_ack(ack_a), .mem_rdata(rdata_a),
        .mem_rvalid(rvalid_a), .mem_done(done_a), .mem_busy(busy_a)
    );

    main_memory_ctrl #(.ADDR_W(10), .DEPTH(256), .BLOCK_WORDS(8), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .mem_req(req_b), .mem_we(we), .mem_addr(addr[9:0]),
        .mem_wdata(wdata), .mem_wdata_ack(ack_b), .mem_rdata(rdata_b),
        .mem_rvalid(rvalid_b), .mem_done(done_b), .mem_busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int blk_base(input int s, input logic [11:0] a);
        int bw = (s != 0) ? 8 : 4;
        return ((int'(a) >> 2) & 255) & ~(bw - 1);
    endfunction

    // abort_beat >= 0 asserts reset in the cycle of that write beat, before it is consumed.
    task automatic do_write(input int s, input logic [11:0] a, input logic [31:0] d0, input int abort_beat);
        int lat = (s != 0) ? 1 : 4;
        int bw  = (s != 0) ? 8 : 4;
        int base = blk_base(s, a);
        int first_ack = -1, nack = 0, done_c = -1;
        @(negedge clk);
        sel = s; req = 1'b1; we = 1'b1; addr = a;
        for (int c = 1; c <= lat + bw + 3; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (ack) begin
                if (nack == abort_beat) begin
                    reset = 1'b1;
                    #1;
                    check("wr_abort_ack", 32'(ack), 32'd0);
                    check("wr_abort_busy", 32'(busy), 32'd0);
                    check("wr_abort_done", 32'(done), 32'd0);
                    @(negedge clk);
                    reset = 1'b0;
                    return;
                end
                if (first_ack < 0) first_ack = c;
                wdata = d0 + 32'(nack);
                ref_mem[s][base + nack] = d0 + 32'(nack);
                nack++;
            end
            if (done) done_c = c;
            if (c == lat + bw + 2) check("wr_busy_end", 32'(busy), 32'd0);
        end
        check("wr_first_ack", 32'(first_ack), 32'(lat + 1));
        check("wr_beats", 32'(nack), 32'(bw));
        check("wr_done_cycle", 32'(done_c), 32'(lat + bw + 1));
    endtask

    // abort_after > 0 asserts reset once that many read beats have been received.
    task automatic do_read(input int s, input logic [11:0] a, input int abort_after);
        int lat = (s != 0) ? 1 : 4;
        int bw  = (s != 0) ? 8 : 4;
        int base = blk_base(s, a);
        int first_rv = -1, nrv = 0, done_c = -1;
        for (int k = 0; k < bw; k++) exp_q.push_back(ref_mem[s][base + k]);
        @(negedge clk);
        sel = s; req = 1'b1; we = 1'b0; addr = a;
        for (int c = 1; c <= lat + bw + 3; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (abort_after > 0 && nrv == abort_after) begin
                reset = 1'b1;
                #1;
                check("rd_abort_rvalid", 32'(rvalid), 32'd0);
                check("rd_abort_busy", 32'(busy), 32'd0);
                check("rd_abort_done", 32'(done), 32'd0);
                check("rd_abort_rdata", rdata, 32'd0);
                @(negedge clk);
                reset = 1'b0;
                check("rd_abort_no_done", 32'(done), 32'd0);
                exp_q.delete();
                return;
            end
            if (rvalid) begin
                if (first_rv < 0) first_rv = c;
                if (exp_q.size() == 0) check("rd_extra_beat", 32'd1, 32'd0);
                else check("rd_data", rdata, exp_q.pop_front());
                nrv++;
            end
            if (done) done_c = c;
            if (c == lat + bw + 2) check("rd_busy_end", 32'(busy), 32'd0);
        end
        check("rd_first_valid", 32'(first_rv), 32'(lat + 1));
        check("rd_beats", 32'(nrv), 32'(bw));
        check("rd_done_cycle", 32'(done_c), 32'(lat + bw + 1));
        check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic held_req_test();
        int r1 = -1, r2 = -1, rises = 0, nrv = 0;
        logic prev = 1'b0;
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < 4; k++) exp_q.push_back(ref_mem[0][16 + k]);
        @(negedge clk);
        sel = 0; req = 1'b1; we = 1'b0; addr = 12'h040;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy && !prev) begin
                rises++;
                if (r1 < 0) r1 = c;
                else if (r2 < 0) begin
                    r2 = c;
                    req = 1'b0;
                end
            end
            prev = busy;
            if (rvalid) begin
                if (exp_q.size() == 0) check("held_extra_beat", 32'd1, 32'd0);
                else check("held_rd_data", rdata, exp_q.pop_front());
                nrv++;
            end
        end
        check("held_accept_spacing", 32'(r2 - r1), 32'd10);
        check("held_txn_count", 32'(rises), 32'd2);
        check("held_beats", 32'(nrv), 32'd8);
        check("held_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("rst_ack_a", 32'(ack_a), 32'd0);
        check("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_write(0, 12'h040, 32'hA0A0_0000, -1);
        do_read(0, 12'h04C, 0);

        do_read(0, 12'h040, 2);
        do_read(0, 12'h040, 0);

        held_req_test();

        do_write(0, 12'h3F0, 32'hB000_0000, -1);
        do_read(0, 12'h7F4, 0);
        do_read(0, 12'h3F3, 0);

        do_write(0, 12'h080, 32'hC000_0000, -1);
        do_write(0, 12'h080, 32'hD000_0000, 2);
        do_read(0, 12'h080, 0);

        do_write(1, 12'h100, 32'hE000_0000, -1);
        do_read(1, 12'h104, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
Backing-store responder for the data cache's miss/write-back path. On a request it waits a programmable access latency, then moves one whole cache block as a burst of 32-bit words. Read bursts are returned on mem_rdata; write bursts are consumed from mem_wdata. It sits behind memory_system and lets the cache's stall/refill logic be exercised against realistic multi-cycle main-memory timing.

Parameters:
ADDR_W, 10, byte-address width of mem_addr.
DEPTH, 256, storage size in 32-bit words; must be a power of 2.
BLOCK_WORDS, 4, words per burst (cache line); must be a power of 2 and ≤ DEPTH.
LATENCY, 4, wait cycles between request accept and first beat; must be ≥ 1.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
mem_req  in  1  request strobe; sampled only in IDLE
mem_we  in  1  1 = write burst, 0 = read burst; sampled with mem_req
mem_addr  in  ADDR_W  byte address; any address within the block is accepted
mem_wdata  in  32  write beat data; sampled on edges where mem_wdata_ack=1
mem_wdata_ack  out  1  current write beat is consumed at this edge; initiator advances its word
mem_rdata  out  32  read beat data, valid when mem_rvalid=1
mem_rvalid  out  1  read beat valid
mem_done  out  1  one-cycle pulse at end of burst
mem_busy  out  1  transaction in progress (not IDLE)

Behaviour:
- Reset (async, active-high): FSM→IDLE; counter and beat index → 0; mem_wdata_ack, mem_rvalid, mem_done, mem_busy → 0; mem_rdata → 0. Storage contents are NOT cleared.
- FSM states: IDLE, WAIT, RD_BURST, WR_BURST, DONE.
- IDLE: on an edge with mem_req=1 (accept edge E0):
  - latch base = word index (mem_addr >> 2) with the low log2(BLOCK_WORDS) bits cleared, modulo DEPTH;
  - latch mem_we;
  - load counter = LATENCY-1;
  - go to WAIT.
- WAIT: decrement counter each edge. When counter = 0, go to RD_BURST or WR_BURST with beat = 0. WAIT lasts exactly LATENCY cycles.
- RD_BURST:
  - mem_rvalid and mem_rdata are registered;
  - mem_rvalid=1 for exactly BLOCK_WORDS consecutive cycles, beginning in the cycle after edge E0+LATENCY;
  - beat k carries word[base+k], k = 0..BLOCK_WORDS-1, in ascending order;
  - no backpressure.
- WR_BURST:
  - mem_wdata_ack=1 combinationally from state, for BLOCK_WORDS consecutive cycles;
  - on each such edge, word[base+beat] ← mem_wdata and beat increments.
- Burst exit: after the last beat, go to DONE.
- DONE: mem_done=1 for one cycle, then IDLE. mem_busy=1 in WAIT, RD_BURST, WR_BURST and DONE.
- Request timing:
  - mem_req is ignored in every state except IDLE;
  - a request held high through DONE is accepted on the first IDLE edge, so the minimum request-to-request spacing is LATENCY+BLOCK_WORDS+2 cycles.
- Address arithmetic:
  - bits of mem_addr above log2(DEPTH)+2 are ignored (wrap modulo DEPTH);
  - base+k never crosses a block boundary, because the base is block-aligned;
  - bits [1:0] of mem_addr are ignored.
- Reset mid-transaction: aborts immediately with all outputs 0. Words already written in a partial write burst remain. No mem_done is issued.
- Read data is the array content at the time of the beat. No read-during-write hazard exists, because bursts are exclusive.

Decomposition:
- Shared package riscv_mem_pkg:
  - WORD_W = 32;
  - default BLOCK_WORDS and LATENCY;
  - FSM state enum (IDLE, WAIT, RD_BURST, WR_BURST, DONE).
  memory_system sizes its line from the same constants.
- One sub-module, main_memory_array:
  - DEPTH×32 storage;
  - synchronous write port (we, waddr, wdata);
  - combinational read port.
- main_memory_ctrl holds the FSM, latency counter, beat index and output registers.

Test Plan:
- Write then read (defaults): write at mem_addr=0x040 with beats 0xA0A0_0000..0xA0A0_0003 → mem_wdata_ack high in cycles 5–8 after accept, mem_done in cycle 9. Then read at mem_addr=0x04C → mem_rvalid in cycles 5–8 returning 0xA0A0_0000, _0001, _0002, _0003.
- Reset mid-read: assert reset after 2 read beats → mem_rvalid, mem_busy and mem_done drop to 0 asynchronously, with no mem_done. A fresh read of 0x040 then returns the full block correctly.
- Request handling: mem_req held high continuously → requests during WAIT/burst/DONE are ignored. A second transaction is accepted on the IDLE edge, with accept edges 10 cycles apart (4+4+2).
- Top block and wrap: write at 0x3F0 → words 252–255 written. Read at 0x7F4 (bit 10 ignored under DEPTH=256, ADDR_W=12 variant) → same four words.
- LATENCY=1, BLOCK_WORDS=8 variant: read → first mem_rvalid in the cycle after edge E0+1, 8 consecutive beats, then mem_done.
- Partial write then reset: reset during write beat 2 of 0x080 → words 32–33 updated, words 34–35 keep their prior values on readback.
